// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: 0.01 s prescaler, SS.hh BCD carry chain, run/pause/lap/clear FSM
// and the live-or-lap display digit mux.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 1_000_000
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [3:0] disp_d0,
  output logic [3:0] disp_d1,
  output logic [3:0] disp_d2,
  output logic [3:0] disp_d3,
  output logic       running,
  output logic       lap_active,
  output logic       tick,
  output logic       wrap
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_LAP   = 2'd2;
  localparam logic [1:0] S_PAUSE = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          capture;
  logic          zero_all;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;
  logic          counting;
  logic          adv;
  logic [15:0]   live;
  logic [15:0]   live_inc;
  logic [15:0]   lap_snap;
  logic          c0, c1, c2;
  logic          at_max;

  // State register
  always_ff @(posedge clk_in) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state plus the one-edge side effects (lap capture, clear)
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    zero_all  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_stop) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (start_stop) begin
          state_nxt = S_PAUSE;
        end else if (lap) begin
          state_nxt = S_LAP;
          capture   = 1'b1;
        end
      end
      S_LAP: begin
        if (start_stop)  state_nxt = S_PAUSE;
        else if (lap)    state_nxt = S_RUN;
      end
      S_PAUSE: begin
        if (clear) begin
          state_nxt = S_IDLE;
          zero_all  = 1'b1;
        end else if (start_stop) begin
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign counting = (state == S_RUN) || (state == S_LAP);
  assign adv      = counting && (presc == PRESC_MAX);

  // Prescaler: counts in RUN/LAP, holds in PAUSE so resume finishes the partial tick
  always_comb begin
    presc_nxt = presc;
    if (zero_all || (state == S_IDLE)) presc_nxt = '0;
    else if (adv)                      presc_nxt = '0;
    else if (counting)                 presc_nxt = presc + PW'(1);
  end

  // BCD carry chain; >= guards keep digits inside their limits
  assign c0 = (live[3:0]   >= 4'd9);
  assign c1 = (live[7:4]   >= 4'd9);
  assign c2 = (live[11:8]  >= 4'd9);
  assign at_max = c0 && c1 && c2 && (live[15:12] >= 4'd5);

  always_comb begin
    live_inc        = live;
    live_inc[3:0]   = c0 ? 4'd0 : live[3:0] + 4'd1;
    if (c0)
      live_inc[7:4]   = c1 ? 4'd0 : live[7:4] + 4'd1;
    if (c0 && c1)
      live_inc[11:8]  = c2 ? 4'd0 : live[11:8] + 4'd1;
    if (c0 && c1 && c2)
      live_inc[15:12] = (live[15:12] >= 4'd5) ? 4'd0 : live[15:12] + 4'd1;
  end

  // Datapath registers; lap capture takes the pre-increment value
  always_ff @(posedge clk_in) begin
    if (reset) begin
      presc    <= '0;
      live     <= '0;
      lap_snap <= '0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      presc <= presc_nxt;
      tick  <= adv;
      wrap  <= adv && at_max;
      if (zero_all) begin
        live     <= '0;
        lap_snap <= '0;
      end else begin
        if (adv)     live     <= live_inc;
        if (capture) lap_snap <= live;
      end
    end
  end

  assign running    = counting;
  assign lap_active = (state == S_LAP);
  assign {disp_d3, disp_d2, disp_d1, disp_d0} = (state == S_LAP) ? lap_snap : live;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for the stopwatch digit chain. It owns the 0.01 s prescaler, a four-digit BCD carry chain (SS.hh, 00.00–59.99) and the run/pause/lap/clear state machine. It also drives the display digit bus, which shows either the live count or a frozen lap snapshot. It sits between the button-pulse front end (already debounced, one-cycle pulses) and the seven-segment multiplexer.

## Interface
- TICK_DIV, 1_000_000: clk_in cycles per 0.01 s tick; legal range ≥ 2.
- clk_in  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the clk_in rising edge.
- start_stop  in  1  one-cycle pulse: start, pause or resume.
- lap  in  1  one-cycle pulse: freeze or release the display.
- clear  in  1  one-cycle pulse: zero the count (honoured in PAUSE only).
- disp_d0  out  4  displayed hundredths, 0–9.
- disp_d1  out  4  displayed tenths, 0–9.
- disp_d2  out  4  displayed seconds ones, 0–9.
- disp_d3  out  4  displayed seconds tens, 0–5.
- running  out  1  high in RUN and LAP.
- lap_active  out  1  high in LAP.
- tick  out  1  one-cycle pulse on each 0.01 s increment.
- wrap  out  1  one-cycle pulse when the count rolls from 59.99 to 00.00.

## Operation
- Reset:
  - state = IDLE.
  - prescaler = 0.
  - live digits = 0.
  - lap digits = 0.
  - All outputs are 0.
- States and transitions (evaluated each edge; at most one transition per edge):
  - IDLE: start_stop → RUN. lap and clear are ignored.
  - RUN: start_stop → PAUSE. lap → LAP, capturing the live digits into the lap register on the same edge.
  - LAP: start_stop → PAUSE. lap → RUN (display returns to live). The live count keeps running while in LAP.
  - PAUSE: start_stop → RUN. clear → IDLE, zeroing the live digits, lap register and prescaler on that edge.
- Priority on simultaneous pulses:
  - In PAUSE, clear beats start_stop.
  - In RUN and LAP, start_stop beats lap.
  - clear is ignored in RUN and LAP.
- Prescaler: width $clog2(TICK_DIV).
  - RUN/LAP: increments each cycle. When it equals TICK_DIV-1 it loads 0 and the carry chain advances on the same edge.
  - PAUSE: holds its value, so a resume continues the partial tick.
  - IDLE: held at 0.
- Carry chain on each advance:
  - d0 increments. d0 at 9 → 0 with carry into d1.
  - d1 at 9 → 0 with carry into d2.
  - d2 at 9 → 0 with carry into d3.
  - d3 at 5 with carry → 0.
  - 59.99 → 00.00; the stopwatch keeps running.
  - Digits never take values outside their limits.
- Display mux (combinational from registers): disp_dN = lap register when state = LAP, else live digit N.
- Entering LAP from RUN while a tick fires on the same edge: the lap register captures the pre-increment value.

## Timing
- All state, digits and prescaler are registered. The status outputs (running, lap_active) decode state combinationally and are valid in the first cycle of the new state.
- tick and wrap are registered. Each is high for exactly the one cycle following the edge at which the digits changed.
- Latency from start:
  - start_stop sampled at edge k → state = RUN after edge k.
  - The first increment (d0 = 1) appears after edge k + TICK_DIV.
- Pause/resume is exact: total RUN/LAP cycles / TICK_DIV = displayed hundredths.
- lap sampled at edge k → disp frozen from the cycle after edge k. A second lap at edge m → disp shows live from the cycle after edge m.
- reset asserted mid-run overrides all pulses on that edge. The block returns to the reset values after that edge.

## Test plan
Run with TICK_DIV = 4.
- Reset, then start_stop at edge 0 → running = 1 after edge 0. disp = 00.01 after edge 4, 00.10 after edge 40. tick pulses every 4 cycles.
- Run to 59.99, then one more tick → disp = 00.00, wrap high for exactly one cycle, running stays 1.
- At 12.34 with prescaler = 2, start_stop → PAUSE, hold 50 cycles. Then start_stop → d0 advances to 5 exactly 2 cycles after resume.
- At 03.07, lap → disp holds 03.07 while the live count continues. Second lap after 20 ticks → disp = 03.27 and lap_active = 0.
- In PAUSE at 05.00, assert clear and start_stop on the same edge → IDLE, disp = 00.00, running = 0. clear pulsed during RUN → no effect.
- Assert reset mid-LAP at 41.22 → all outputs 0 on the next cycle. A start_stop on the reset edge is ignored.
